alu_seq: RTL

Parametrised, registered successor to the 32-bit ripple-carry ALU: a WIDTH-bit ALU with valid/ready handshakes on operands and results. It keeps the 4-bit ALU_control encoding and zero/cout/overflow flags. It adds an iterative shift-add multiply that takes WIDTH cycles. It sits between the decode/operand stage and writeback in the lab CPU datapath, and it stalls the producer while a multiply is in flight.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_mul_iter.sv | 74 +++++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_seq slice.
//   - OP_*    : 4-bit ALU_control encodings carried over from the ripple-carry ALU
//   - state_t : control FSM states of alu_seq
// Optional feature macro: ALU_MUL_EN (see alu_seq.sv).
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq.
//   operand side : in_valid_i, in_ready_o, src1_i, src2_i, ALU_control_i
//   result side  : out_valid_o, out_ready_i, result_o, zero_o, cout_o,
//                  overflow_o, illegal_o
// Signal names keep the _i/_o suffixes as seen from the ALU.
// master = producer/consumer around the ALU, slave = the ALU itself.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ALU_control_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;
    logic             illegal_o;

    modport master (
        output in_valid_i, src1_i, src2_i, ALU_control_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, cout_o,
               overflow_o, illegal_o
    );

    modport slave (
        input  in_valid_i, src1_i, src2_i, ALU_control_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, cout_o,
               overflow_o, illegal_o
    );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned iterative shift-add multiplier, one multiplier bit
// per cycle over WIDTH cycles, 2*WIDTH-bit accumulator ({hi_q, lo_q}).
//   clk_i, rst_i : clock, asynchronous active-high reset (discards partial product)
//   start_i      : load operands a_i (multiplicand) and b_i (multiplier)
//   done_o       : high during the final iteration cycle
//   product_o    : accumulator value after the current iteration; holds the
//                  full product while done_o is high
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // lo_q starts as the multiplier and fills with product bits from the top
    // as it shifts right; the add carry lands in hi_n's MSB.
    always_comb begin
        addend = lo_q[0] ? mcand_q : '0;
        sum    = {1'b0, hi_q} + {1'b0, addend};
        hi_n   = sum[WIDTH:1];
        lo_n   = {sum[0], lo_q[WIDTH-1:1]};
    end

    // The product is offered combinationally on the last iteration so the
    // parent can register it at the same edge, giving a latency of WIDTH.
    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = {hi_n, lo_n};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= a_i;
            hi_q    <= '0;
            lo_q    <= b_i;
        end else if (busy_q) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : alu_seq_if.slave (operands/opcode in, result + zero/cout/
//           overflow/illegal flags out)
// Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR) are computed combinationally and
// registered at the accept edge. MUL (opcode 1000) is an iterative shift-add
// taking WIDTH cycles, present only when macro ALU_MUL_EN is defined;
// otherwise 1000 is reported as illegal like any other unlisted code.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    alu_seq_if.slave    bus
);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a, b;
    logic [3:0]       op;
    logic             accept;
    logic             drain;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, cout_q, ovf_q, ill_q;

    // single-cycle datapath
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic             c_msb_in;
    logic             as_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout, alu_ovf, alu_ill;
    logic             op_mul;

    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign a  = bus.src1_i;
    assign b  = bus.src2_i;
    assign op = bus.ALU_control_i;

    assign drain          = out_valid_q && bus.out_ready_i;
    assign bus.in_ready_o = (state_q == IDLE) && (!out_valid_q || bus.out_ready_i);
    assign accept         = bus.in_valid_i && bus.in_ready_o;

    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.zero_o      = zero_q;
    assign bus.cout_o      = cout_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.illegal_o   = ill_q;

    always_comb begin
        is_sub   = (op == OP_SUB) || (op == OP_SLT);
        b_eff    = is_sub ? ~b : b;
        sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        c_msb_in = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1];
        as_ovf   = c_msb_in ^ sum_full[WIDTH];

        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        op_mul   = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD, OP_SUB: begin
                alu_res  = sum_full[WIDTH-1:0];
                alu_cout = sum_full[WIDTH];
                alu_ovf  = as_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum_full[WIDTH-1] ^ as_ovf};
`ifdef ALU_MUL_EN
            OP_MUL: op_mul = 1'b1;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    logic mul_start;
    assign mul_start = accept && op_mul;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    // FSM: the acceptance gate in in_ready_o already stalls single-cycle ops
    // behind an undrained result, so only a finished MUL can enter HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && op_mul) state_d = MUL;
            MUL:  if (mul_done) state_d = bus.out_ready_i ? IDLE : HOLD;
            HOLD: if (drain) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Output register: a new result takes priority over a drain in the same
    // cycle, which gives back-to-back throughput without a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else if (accept && !op_mul) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            zero_q      <= (alu_res == '0);
            cout_q      <= alu_cout;
            ovf_q       <= alu_ovf;
            ill_q       <= alu_ill;
        end else if (mul_done) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[WIDTH-1:0];
            zero_q      <= (mul_prod[WIDTH-1:0] == '0);
            cout_q      <= |mul_prod[2*WIDTH-1:WIDTH];
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
